// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
//  Module      : instr_sequencer_pkg
//  Description : Shared state encoding and opcode constants for the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_LD = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [5:0] C_ALU    = 6'h00;
    localparam logic [5:0] C_SHIFT  = 6'h01;
    localparam logic [5:0] C_MEM    = 6'h02;
    localparam logic [5:0] C_BRANCH = 6'h03;
    localparam logic [5:0] C_JUMP   = 6'h04;
    localparam logic [5:0] C_CMP    = 6'h05;
    localparam logic [5:0] C_IMM    = 6'h06;
    localparam logic [5:0] C_HALT   = 6'h3F;

    localparam logic [5:0] C_LOAD   = 6'h01;
    localparam logic [5:0] C_STORE  = 6'h02;

    // Everything between IMM and HALT is unassigned.
    function automatic logic is_illegal(input logic [5:0] op_type);
        return (op_type > C_IMM) && (op_type < C_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch / issue sequencer with load wait and halt handling.
//                Define SEQ_ILLEGAL_TRAP_EN to halt on illegal opcode types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] start_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic [63:0] instr_out,
    input  logic [5:0]  opcode_type,
    input  logic [5:0]  opcode,
    input  logic [15:0] mem_addr,
    input  logic        flag_set,
    output logic        issue_valid,
    input  logic        issue_ready,
    input  logic        ld_done,
    input  logic        cmp_result,
    output logic [15:0] pc,
    output logic        flag,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_flag;
    logic [63:0] r_instr;
    logic        r_imem_req;
    logic [15:0] r_imem_addr;
    logic        r_issue_valid;
    logic        r_busy;
    logic        r_halted;
    logic        r_illegal;

    logic [15:0] w_pc_inc;
    logic [15:0] w_next_pc;
    state_t      w_next_state;
    logic        w_trap;

    // Decode of the instruction being issued; only consumed in S_ISSUE.
    always_comb begin
        w_pc_inc     = r_pc + 16'd1;
        w_next_pc    = w_pc_inc;
        w_next_state = S_FETCH;
        w_trap       = 1'b0;
        case (opcode_type)
            C_BRANCH: w_next_pc = r_flag ? mem_addr : w_pc_inc;
            C_JUMP:   w_next_pc = mem_addr;
            C_MEM:    if (opcode == C_LOAD) w_next_state = S_WAIT_LD;
            C_HALT: begin
                w_next_pc    = r_pc;
                w_next_state = S_HALT;
            end
            default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                if (is_illegal(opcode_type)) begin
                    w_next_pc    = r_pc;
                    w_next_state = S_HALT;
                    w_trap       = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= 16'h0000;
            r_flag        <= 1'b0;
            r_instr       <= 64'h0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= 16'h0000;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc        <= start_pc;
                        r_imem_addr <= start_pc;
                        r_imem_req  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_halted    <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_issue_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        r_issue_valid <= 1'b0;
                        r_pc          <= w_next_pc;
                        r_state       <= w_next_state;
                        if (flag_set) r_flag <= cmp_result;
                        case (w_next_state)
                            S_FETCH: begin
                                r_imem_req  <= 1'b1;
                                r_imem_addr <= w_next_pc;
                            end
                            S_HALT: begin
                                r_halted  <= 1'b1;
                                r_busy    <= 1'b0;
                                r_illegal <= w_trap;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT_LD: begin
                    if (ld_done) begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                        r_state     <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc          = r_pc;
    assign flag        = r_flag;
    assign instr_out   = r_instr;
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign issue_valid = r_issue_valid;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

`default_nettype wire
